dom_dep_multibit_seq: RTL

Sequential, lane-folded masked AND unit for multi-bit operands. It computes a BIT_WIDTH-bit DOM-dep AND of two share-encoded operands, using only LANES instances of the existing dom_dep gadget over BIT_WIDTH/LANES cycles. This trades latency for area and randomness bandwidth. It sits between the B2A/masked-ALU datapath and the randomness source, with valid/ready handshakes on the operand, randomness and result sides.

---
 rtl/dom_dep_multibit_seq.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/dom_dep_multibit_seq.sv
// Lane-folded masked AND: LANES dom_dep gadgets process a BIT_WIDTH-bit shared operand
// pair chunk by chunk. A tag pipeline tracks which chunk each gadget output belongs to.

module dom_dep #(
  parameter int D          = 1,
  parameter int PIPELINING = 1,
  parameter int N          = D + 1,
  parameter int L          = (D + 1) * D / 2
) (
  input  logic         clk,
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  input  logic [N-1:0] r1_i,
  input  logic [L-1:0] r2_i,
  output logic [N-1:0] c_o
);

  function automatic int pair_idx(input int i, input int j);
    return i * N - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  logic [N*N-1:0] cross_d;
  logic [N*N-1:0] cross_p0;
  logic [N-1:0]   x_p0;
  logic [N-1:0]   b_p0;
  logic [N-1:0]   c_comb;
  logic           bsum;

  always_comb begin
    cross_d = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i == j)     cross_d[i*N+j] = x_i[i] & r1_i[j];
        else if (i < j) cross_d[i*N+j] = (x_i[i] & r1_i[j]) ^ r2_i[pair_idx(i, j)];
        else            cross_d[i*N+j] = (x_i[i] & r1_i[j]) ^ r2_i[pair_idx(j, i)];
      end
    end
  end

  // Stage p0: blinded y (y ^ z) and resharing cross terms registered before any recombination
  always_ff @(posedge clk) begin
    x_p0     <= x_i;
    b_p0     <= y_i ^ r1_i;
    cross_p0 <= cross_d;
  end

  always_comb begin
    c_comb = '0;
    bsum   = ^b_p0;
    for (int i = 0; i < N; i++) begin
      c_comb[i] = x_p0[i] & bsum;
      for (int j = 0; j < N; j++) c_comb[i] = c_comb[i] ^ cross_p0[i*N+j];
    end
  end

  // Stage p1: optional output register
  if (PIPELINING != 0) begin : g_pipe
    logic [N-1:0] c_p1;
    always_ff @(posedge clk) c_p1 <= c_comb;
    assign c_o = c_p1;
  end else begin : g_comb
    assign c_o = c_comb;
  end

endmodule

module dom_dep_multibit_seq #(
  parameter int D          = 1,
  parameter int BIT_WIDTH  = 8,
  parameter int LANES      = 2,
  parameter int PIPELINING = 1,
  parameter int N          = D + 1,
  parameter int L          = (D + 1) * D / 2,
  parameter int K          = BIT_WIDTH / LANES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*BIT_WIDTH-1:0] port_a,
  input  logic [N*BIT_WIDTH-1:0] port_b,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  input  logic [N*LANES-1:0]     port_r1,
  input  logic [L*LANES-1:0]     port_r2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*BIT_WIDTH-1:0] port_c,
  output logic                   busy
);

  localparam int GL    = 1 + PIPELINING;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam int NB    = N * BIT_WIDTH;

  if (BIT_WIDTH % LANES != 0) begin : g_bad_cfg
    $error("BIT_WIDTH must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [GL-1:0]              tag_vld_q, tag_vld_d;
  logic [GL-1:0][IDX_W-1:0]   tag_idx_q, tag_idx_d;
  logic [NB-1:0]              a_q, a_d, b_q, b_d, c_q, c_d;
  logic [N*LANES-1:0]         lane_x, lane_y, lane_c;
  logic                       issue;

  assign issue = (state_q == RUN) && rnd_valid;

  // Idle cycles feed zeros so stale operand shares never meet in a gadget
  always_comb begin
    lane_x = '0;
    lane_y = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < N; s++) begin
        if (issue) begin
          lane_x[l*N+s] = a_q[(int'(idx_q) * LANES + l) * N + s];
          lane_y[l*N+s] = b_q[(int'(idx_q) * LANES + l) * N + s];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dom_dep #(.D(D), .PIPELINING(PIPELINING), .N(N), .L(L)) u_gadget (
      .clk  (clk),
      .x_i  (lane_x[l*N +: N]),
      .y_i  (lane_y[l*N +: N]),
      .r1_i (port_r1[l*N +: N]),
      .r2_i (port_r2[l*L +: L]),
      .c_o  (lane_c[l*N +: N])
    );
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    tag_vld_d = tag_vld_q;
    tag_idx_d = tag_idx_q;

    for (int g = GL - 1; g > 0; g--) begin
      tag_vld_d[g] = tag_vld_q[g-1];
      tag_idx_d[g] = tag_idx_q[g-1];
    end
    tag_vld_d[0] = issue;
    tag_idx_d[0] = idx_q;

    if (tag_vld_q[GL-1]) begin
      for (int l = 0; l < LANES; l++) begin
        for (int s = 0; s < N; s++) begin
          c_d[(int'(tag_idx_q[GL-1]) * LANES + l) * N + s] = lane_c[l*N+s];
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = port_a;
          b_d     = port_b;
          c_d     = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(K - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tag_vld_q == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tag_vld_q <= '0;
      tag_idx_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign rnd_ready = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign port_c    = c_q;

endmodule
